if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 24 ++
 rtl/if_fifo2.sv | 53 +++++
 rtl/if_stage.sv | 117 +++++++++++
 tb/tb_if_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
`timescale 1ns/1ps
// Shared constants and types for the instruction fetch stage: bus widths, logic levels,
// PC increment and the fetch FSM state encoding.
package if_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic TRUE      = 1'b1;
    localparam logic FALSE     = 1'b0;
    localparam logic RST_LEVEL = 1'b1;

    localparam logic [XLEN-1:0] ZERO   = '0;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [0:0] {
        StFetch = 1'b0,
        StDrain = 1'b1
    } if_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fifo2.sv
`timescale 1ns/1ps
// Two-entry {addr, inst} buffer between the fetch bus and the decode stage.
// clear empties it in the same edge, overriding any push or pop.
module if_fifo2
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_addr,
    input  logic [XLEN-1:0] push_inst,
    output logic [XLEN-1:0] head_addr,
    output logic [XLEN-1:0] head_inst,
    output logic [1:0]      count
);

    logic [XLEN-1:0] addr_q [2];
    logic [XLEN-1:0] inst_q [2];
    logic            rd_ptr_q;
    logic            wr_ptr_q;
    logic [1:0]      count_q;

    always_ff @(posedge clk) begin
        if (rst == RST_LEVEL || clear) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Payload needs no reset: it is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= push_addr;
            inst_q[wr_ptr_q] <= push_inst;
        end
    end

    assign head_addr = addr_q[rd_ptr_q];
    assign head_inst = inst_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/if_stage.sv
`timescale 1ns/1ps
// Instruction fetch stage: sequential PC, one outstanding imem request, 2-deep output buffer.
// Defining IF_FETCH_CNT_EN adds fetch_cnt_o, a count of instructions handed downstream.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_addr_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_data_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_addr_o,
    output logic [XLEN-1:0] inst_o
`ifdef IF_FETCH_CNT_EN
    ,
    output logic [XLEN-1:0] fetch_cnt_o
`endif
);

    if_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] drain_addr_q, drain_addr_d;
    logic [XLEN-1:0] head_addr, head_inst;
    logic [1:0]      count;
    logic            in_rst, req, xfer, push, pop;

    assign in_rst = (rst == RST_LEVEL);

    // Issuing only with a free slot guarantees every acked word can be pushed.
    assign req  = in_rst ? FALSE : ((state_q == StDrain) || (count <= 2'd1));
    assign xfer = req && imem_ack_i;
    assign push = xfer && (state_q == StFetch) && !redirect_i;

    assign inst_valid_o = !in_rst && (count != 2'd0);
    assign pop          = inst_valid_o && !stall_i && !redirect_i;

    assign imem_req_o  = req;
    assign imem_addr_o = in_rst ? RESET_PC : ((state_q == StDrain) ? drain_addr_q : pc_q);
    assign inst_o      = in_rst ? ZERO : head_inst;
    assign inst_addr_o = in_rst ? ZERO : head_addr;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        unique case (state_q)
            StFetch: begin
                if (redirect_i) begin
                    pc_d = word_align(redirect_addr_i);
                    // An un-acked request must stay on the bus; its data is dropped later.
                    if (req && !imem_ack_i) begin
                        state_d      = StDrain;
                        drain_addr_d = pc_q;
                    end
                end else if (xfer) begin
                    pc_d = pc_q + PC_INC;
                end
            end
            StDrain: begin
                if (redirect_i) begin
                    pc_d = word_align(redirect_addr_i);
                end
                if (imem_ack_i) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_rst) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    if_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_i),
        .push      (push),
        .pop       (pop),
        .push_addr (pc_q),
        .push_inst (imem_data_i),
        .head_addr (head_addr),
        .head_inst (head_inst),
        .count     (count)
    );

`ifdef IF_FETCH_CNT_EN
    logic [XLEN-1:0] fetch_cnt_q;

    always_ff @(posedge clk) begin
        if (in_rst || redirect_i) begin
            fetch_cnt_q <= ZERO;
        end else if (pop) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
// Bench for if_stage: directed scenarios plus randomized acks/stalls/redirects/resets,
// scored against the expected sequential address stream. Honours IF_FETCH_CNT_EN.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_addr_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'h0;
    logic        inst_valid_o;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_o;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_cnt_o;
`endif

    if_stage #(
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .inst_valid_o    (inst_valid_o),
        .inst_addr_o     (inst_addr_o),
        .inst_o          (inst_o)
`ifdef IF_FETCH_CNT_EN
        ,
        .fetch_cnt_o     (fetch_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    int          n_pops = 0;
    int          ack_mode = 0;    // 0: ack tied high, 1: random, 2: fixed latency
    int          ack_lat = 0;
    int          wait_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] next_exp = RESET_PC;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: answers the presented address; ack may coincide with the request.
    always @(posedge clk) begin : responder
        logic a;
        #2;
        if (imem_req_o) begin
            case (ack_mode)
                0:       a = 1'b1;
                1:       a = ($urandom_range(0, 2) == 0) || (wait_cnt >= 4);
                default: a = (wait_cnt >= ack_lat);
            endcase
            wait_cnt = a ? 0 : wait_cnt + 1;
        end else begin
            wait_cnt = 0;
            a = (ack_mode == 0) || (ack_mode == 1 && $urandom_range(0, 3) == 0);
        end
        imem_ack_i  = a;
        imem_data_i = a ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;
    end

    // Monitor: every accepted instruction must be the next address of the expected stream.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (!rst) begin
            if (inst_valid_o && !stall_i && !redirect_i) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_addr", inst_addr_o, e);
                    chk("pop_inst", inst_o, mem_word(e));
                end
            end
            if (hold_prev) begin
                chk("req_hold", {31'b0, imem_req_o}, 32'd1);
                chk("addr_hold", imem_addr_o, hold_addr);
            end
            if (imem_req_o) chk("addr_align", imem_addr_o & 32'd3, 32'd0);
        end
        hold_prev = !rst && imem_req_o && !imem_ack_i;
        hold_addr = imem_addr_o;
    end

    // One cycle of stimulus; the expected stream is restarted on reset or redirect.
    task automatic tick(input logic r, input logic s, input logic rd, input logic [31:0] ra);
        @(posedge clk);
        #1;
        rst = r;
        stall_i = s;
        redirect_i = rd;
        redirect_addr_i = ra;
        if (r) begin
            exp_q.delete();
            next_exp = RESET_PC;
        end else if (rd) begin
            exp_q.delete();
            next_exp = {ra[31:2], 2'b00};
        end
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_exp);
            next_exp += 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic idle(); tick(1'b0, 1'b0, 1'b0, 32'h0); endtask
    task automatic do_reset(); tick(1'b1, 1'b0, 1'b0, 32'h0); endtask

    initial begin
        int rand_pops;
        logic r, s, rd;

        // Reset values and streaming with ack tied high.
        ack_mode = 0;
        do_reset();
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_addr", imem_addr_o, RESET_PC);
        chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_inst_addr", inst_addr_o, 32'd0);
        do_reset();
        idle();
        chk("c0_req", {31'b0, imem_req_o}, 32'd1);
        chk("c0_addr", imem_addr_o, 32'h0);
        chk("c0_valid", {31'b0, inst_valid_o}, 32'd0);
`ifdef IF_FETCH_CNT_EN
        chk("cnt_reset", fetch_cnt_o, 32'd0);
`endif
        idle();
        chk("c1_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("c1_ia", inst_addr_o, 32'h0);
        chk("c1_addr", imem_addr_o, 32'h4);
        idle(); chk("c2_ia", inst_addr_o, 32'h4);
        idle(); chk("c3_ia", inst_addr_o, 32'h8);
        idle(); chk("c4_ia", inst_addr_o, 32'hC);

        // Stall five cycles: buffer fills, request drops, then drains in order.
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 32'h0);
        chk("stall_req", {31'b0, imem_req_o}, 32'd0);
        chk("stall_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("stall_ia", inst_addr_o, 32'h0);
        idle(); chk("rel_ia0", inst_addr_o, 32'h0);
        idle(); chk("rel_ia1", inst_addr_o, 32'h4);

        // Late ack at 0x8 with a redirect during the wait: old request drained.
        ack_mode = 2; ack_lat = 0;
        do_reset();
        idle(); idle();
        ack_lat = 3;
        idle(); chk("late_addr_c2", imem_addr_o, 32'h8);
        tick(1'b0, 1'b0, 1'b1, 32'h103);
        chk("late_addr_c3", imem_addr_o, 32'h8);
        idle();
        chk("drain_addr", imem_addr_o, 32'h8);
        chk("drain_valid", {31'b0, inst_valid_o}, 32'd0);
        ack_lat = 0;
        idle();
        chk("drain_ack_addr", imem_addr_o, 32'h8);
        chk("drain_ack_valid", {31'b0, inst_valid_o}, 32'd0);
        idle();
        chk("post_drain_addr", imem_addr_o, 32'h100);
        chk("post_drain_valid", {31'b0, inst_valid_o}, 32'd0);
        idle();
        chk("post_drain_ia", inst_addr_o, 32'h100);

        // Redirect coinciding with a pop and an ack.
        ack_mode = 0;
        do_reset();
        idle();
        tick(1'b0, 1'b0, 1'b1, 32'h40);
        idle();
        chk("redir_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("redir_addr", imem_addr_o, 32'h40);
        idle();
        chk("redir_ia", inst_addr_o, 32'h40);

        // Reset during an outstanding request, ack arriving while in reset.
        ack_mode = 2; ack_lat = 0;
        do_reset();
        idle();
        ack_lat = 5;
        idle();
        ack_mode = 0;
        do_reset();
        chk("midrst_req", {31'b0, imem_req_o}, 32'd0);
        chk("midrst_valid", {31'b0, inst_valid_o}, 32'd0);
        do_reset();
        ack_mode = 2; ack_lat = 2;
        idle();
        chk("restart_addr", imem_addr_o, RESET_PC);
        chk("restart_valid", {31'b0, inst_valid_o}, 32'd0);
        idle(); idle(); idle();
        chk("restart_ia", inst_addr_o, RESET_PC);

        // PC wrap and the optional pop counter.
        ack_mode = 0;
        do_reset();
        idle();
        tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        idle();
        chk("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
`ifdef IF_FETCH_CNT_EN
        chk("cnt_after_redir", fetch_cnt_o, 32'd0);
`endif
        idle();
        chk("wrap_addr1", imem_addr_o, 32'h0);
        chk("wrap_ia0", inst_addr_o, 32'hFFFF_FFFC);
        idle();
        chk("wrap_ia1", inst_addr_o, 32'h0);
`ifdef IF_FETCH_CNT_EN
        chk("cnt_one", fetch_cnt_o, 32'd1);
`endif
        tick(1'b0, 1'b0, 1'b1, 32'h200);
`ifdef IF_FETCH_CNT_EN
        chk("cnt_two", fetch_cnt_o, 32'd2);
`endif
        idle();
`ifdef IF_FETCH_CNT_EN
        chk("cnt_clear", fetch_cnt_o, 32'd0);
`endif

        // Randomized traffic against the stream model.
        ack_mode = 1;
        do_reset();
        rand_pops = n_pops;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rd = !r && ($urandom_range(0, 24) == 0);
            tick(r, s, rd, ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                        : $urandom());
        end
        ack_mode = 0;
        for (int i = 0; i < 10; i++) idle();
        chk("random_progress", {31'b0, (n_pops - rand_pops) > 500}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
